// File: rtl/ulbf_dout_axis2ram_64b.sv
// AXI4-Stream 64-bit capture stage: writes each accepted beat into a RAM port
// and checks TLAST framing against the programmed block size.
module ulbf_dout_axis2ram_64b #(
  parameter int RAM_DEPTH  = 2048,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      s_axis_clk,
  input  logic                      s_axis_rst_n,
  input  logic                      go,
  input  logic [11:0]               block_size,
  input  logic [11:0]               niter,
  input  logic [ADDR_WIDTH-1:0]     rollover_addr,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      ram_en,
  output logic [DATA_WIDTH/8-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  output logic                      done,
  output logic                      busy,
  output logic [15:0]               tlast_err_cnt,
  output logic [31:0]               beat_cnt,
  output logic [ADDR_WIDTH-1:0]     addr_wire
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    go_q, armed_q;
  logic [11:0]             bs_q, bs_d, ni_q, ni_d;
  logic [11:0]             blk_q, blk_d, iter_q, iter_d;
  logic [ADDR_WIDTH-1:0]   roll_q, roll_d, addr_q, addr_d;
  logic [31:0]             beat_q, beat_d;
  logic [15:0]             err_q, err_d;
  logic                    ram_en_q, ram_en_d;
  logic [KEEP_W-1:0]       ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic                    go_rise, accept, blk_last;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // armed_q masks a go that is already high when reset is released
  assign go_rise  = armed_q && go && !go_q;
  assign accept   = s_axis_tvalid && (state_q == RUN);
  assign blk_last = (blk_q == bs_q - 12'd1);

  always_comb begin
    state_d     = state_q;
    bs_d        = bs_q;
    ni_d        = ni_q;
    roll_d      = roll_q;
    blk_d       = blk_q;
    iter_d      = iter_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    err_d       = err_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (go_rise) begin
          bs_d   = block_size;
          ni_d   = niter;
          roll_d = (rollover_addr > MAX_ADDR) ? MAX_ADDR : rollover_addr;
          blk_d  = '0;
          iter_d = '0;
          addr_d = '0;
          beat_d = '0;
          err_d  = '0;
          state_d = (block_size == 12'd0 || niter == 12'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          ram_en_d    = 1'b1;
          ram_we_d    = s_axis_tkeep;
          ram_addr_d  = addr_q;
          ram_wdata_d = s_axis_tdata;
          addr_d = (addr_q == roll_q) ? '0 : addr_q + 1'b1;
          beat_d = beat_q + 32'd1;
          // early tlast or missing tlast both count as one framing error
          if (s_axis_tlast != blk_last) err_d = sat_inc16(err_q);
          if (blk_last) begin
            blk_d  = '0;
            iter_d = iter_q + 12'd1;
            if (iter_q == ni_q - 12'd1) state_d = DONE;
          end else begin
            blk_d = blk_q + 12'd1;
          end
        end
      end
      DONE: begin
        if (!go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      armed_q     <= 1'b0;
      bs_q        <= '0;
      ni_q        <= '0;
      roll_q      <= '0;
      blk_q       <= '0;
      iter_q      <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      err_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go;
      armed_q     <= 1'b1;
      bs_q        <= bs_d;
      ni_q        <= ni_d;
      roll_q      <= roll_d;
      blk_q       <= blk_d;
      iter_q      <= iter_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign s_axis_tready = (state_q == RUN);
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign tlast_err_cnt = err_q;
  assign beat_cnt      = beat_q;
  assign addr_wire     = addr_q;

endmodule
